// File: rtl/vga_draw_ctrl.sv
// rtl/vga_draw_ctrl.sv - CPU-driven rectangle fill controller feeding a VGA framebuffer writer
//
// Ports:
//   clock_50        single clock, rising edge
//   reset           asynchronous active-high reset
//   cpu_data[31:0]  CPU write data
//   cpu_addr[1:0]   register select: 0 pixel, 1 origin, 2 size, 3 control
//   cpu_cs, cpu_we  CPU write strobe (both high)
//   vga_data[31:0]  framebuffer write word {18'b0, row[5:0], col[6:0], pix}
//   vga_cs, vga_we  framebuffer write strobe
//   busy            high while a fill is running
//   done            one-cycle pulse on fill completion or zero-size start
module vga_draw_ctrl (
  input  logic        clock_50,
  input  logic        reset,
  input  logic [31:0] cpu_data,
  input  logic [1:0]  cpu_addr,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  output logic [31:0] vga_data,
  output logic        vga_cs,
  output logic        vga_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_n;

  logic [6:0] x0, x0_n, w, w_n;
  logic [5:0] y0, y0_n, h, h_n;
  logic       color, color_n;
  // Cursor is one bit wider than the origin so x0+w / y0+h never wrap.
  logic [7:0] x, x_n;
  logic [6:0] y, y_n;

  logic [31:0] data_n;
  logic        cs_n;
  logic        done_n;

  logic       cpu_wr;
  logic       ctl_start;
  logic       ctl_abort;
  logic [7:0] x_last;
  logic [6:0] y_last;
  logic       unused_data;

  assign cpu_wr      = cpu_cs & cpu_we;
  // Abort wins over start when both are set in one control write.
  assign ctl_abort   = cpu_wr && (cpu_addr == 2'd3) && cpu_data[1];
  assign ctl_start   = cpu_wr && (cpu_addr == 2'd3) && cpu_data[0] && !cpu_data[1];
  assign x_last      = {1'b0, x0} + {1'b0, w} - 8'd1;
  assign y_last      = {1'b0, y0} + {1'b0, h} - 7'd1;
  assign busy        = (state == FILL);
  assign unused_data = ^cpu_data[31:14];

  always_comb begin
    state_n = state;
    x0_n    = x0;
    y0_n    = y0;
    w_n     = w;
    h_n     = h;
    color_n = color;
    x_n     = x;
    y_n     = y;
    data_n  = 32'd0;
    cs_n    = 1'b0;
    done_n  = 1'b0;

    // Direct CPU pixel writes pass through in any state.
    if (cpu_wr && (cpu_addr == 2'd0)) begin
      data_n = {18'd0, cpu_data[13:0]};
      cs_n   = 1'b1;
    end

    case (state)
      IDLE: begin
        if (cpu_wr && (cpu_addr == 2'd1)) begin
          x0_n = cpu_data[6:0];
          y0_n = cpu_data[13:8];
        end
        if (cpu_wr && (cpu_addr == 2'd2)) begin
          w_n = cpu_data[6:0];
          h_n = cpu_data[13:8];
        end
        if (ctl_start) begin
          if ((w == 7'd0) || (h == 6'd0)) begin
            done_n = 1'b1;
          end else begin
            state_n = FILL;
            color_n = cpu_data[2];
            x_n     = {1'b0, x0};
            y_n     = {1'b0, y0};
          end
        end
      end
      FILL: begin
        // Any CPU write stalls the fill for this cycle; only abort acts.
        if (cpu_wr) begin
          if (ctl_abort) begin
            state_n = IDLE;
          end
        end else begin
          // Off-screen cursor positions still cost a step but write nothing.
          if ((x < 8'd80) && (y < 7'd60)) begin
            data_n = {18'd0, y[5:0], x[6:0], color};
            cs_n   = 1'b1;
          end
          if (x == x_last) begin
            x_n = {1'b0, x0};
            y_n = y + 7'd1;
            if (y == y_last) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            x_n = x + 8'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      x0       <= 7'd0;
      y0       <= 6'd0;
      w        <= 7'd0;
      h        <= 6'd0;
      color    <= 1'b0;
      x        <= 8'd0;
      y        <= 7'd0;
      vga_data <= 32'd0;
      vga_cs   <= 1'b0;
      vga_we   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      x0       <= x0_n;
      y0       <= y0_n;
      w        <= w_n;
      h        <= h_n;
      color    <= color_n;
      x        <= x_n;
      y        <= y_n;
      vga_data <= data_n;
      vga_cs   <= cs_n;
      vga_we   <= cs_n;
      done     <= done_n;
    end
  end

endmodule
